// File: rtl/fp_pkg.sv
// Shared widths, pipeline payload types and the exponent saturation helper
// for the floating-point normalizer.
package fp_pkg;

  localparam int M   = 23;
  localparam int E   = 8;
  localparam int W   = 2 * M + 2;
  localparam int LZW = $clog2(W + 1);
  localparam int XW  = E + 2;

  typedef struct packed {
    logic         sign;
    logic [M:0]   mant;
    logic [E:0]   exp;
    logic         guard;
    logic         round;
    logic         sticky;
    logic         zero;
  } fp_norm_t;

  typedef struct packed {
    logic                 sign;
    logic [W-1:0]         mant;
    logic signed [XW-1:0] exp;
    logic [LZW-1:0]       lz;
  } fp_s1_t;

  // Clamp a non-negative exponent to the largest value the output field can hold.
  function automatic logic [E:0] sat_exp(input logic signed [XW:0] v);
    logic signed [XW:0] lim;
    lim = $signed({{(XW - E){1'b0}}, {(E + 1){1'b1}}});
    if (v > lim) begin
      sat_exp = {(E + 1){1'b1}};
    end else begin
      sat_exp = v[E:0];
    end
  endfunction

endpackage

// File: rtl/fp_normalize_if.sv
// Valid/ready input beat and normalized output toward the rounder.
interface fp_normalize_if import fp_pkg::*; ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [W-1:0]         in_mant;
  logic signed [XW-1:0] in_exp;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic [M:0]           out_mant;
  logic [E:0]           out_exp;
  logic                 out_guard;
  logic                 out_round;
  logic                 out_sticky;
  logic                 out_zero;

  modport slave (
    input  in_valid, in_sign, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_sign, out_mant, out_exp,
           out_guard, out_round, out_sticky, out_zero
  );

  modport master (
    output in_valid, in_sign, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_sign, out_mant, out_exp,
           out_guard, out_round, out_sticky, out_zero
  );

endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter from the MSB; an all-zero input yields W.
module fp_lzc #(
  parameter int W   = 48,
  parameter int LZW = $clog2(W + 1)
) (
  input  logic [W-1:0]   vec_i,
  output logic [LZW-1:0] cnt_o
);

  logic [LZW-1:0] cnt_s;

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    cnt_s = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) begin
        cnt_s = LZW'(W - 1 - i);
      end else begin
        cnt_s = cnt_s;
      end
    end
  end

  assign cnt_o = cnt_s;

endmodule

// File: rtl/fp_normalize.sv
// Two-stage normalizer: S1 captures the operand and its leading-zero count,
// S2 holds the shifted mantissa, exponent and GRS bits for the rounder.
module fp_normalize import fp_pkg::*; (
  input logic          clk,
  input logic          rst,
  fp_normalize_if.slave bus
);

  logic           s1_valid_q, s1_valid_d;
  fp_s1_t         s1_q, s1_d;
  logic           out_valid_q, out_valid_d;
  fp_norm_t       out_q, out_d;
  fp_norm_t       norm_s;
  logic           s1_en_s, s2_en_s;
  logic [LZW-1:0] lz_s;

  logic signed [XW:0] exp_x_s, lz_x_s, exp_full_s, neg_exp_s;
  logic [LZW-1:0]     lsh_s, rsh_s;
  logic               use_right_s, lost_s;
  logic [W-1:0]       shl_s, shv_s;
  logic [2*W-1:0]     ext_s;

  fp_lzc #(.W(W)) u_lzc (
    .vec_i (bus.in_mant),
    .cnt_o (lz_s)
  );

  assign s2_en_s      = !out_valid_q | bus.out_ready;
  assign s1_en_s      = !s1_valid_q | s2_en_s;
  assign bus.in_ready = s1_en_s;

  // S1 load: capture the accepted beat with its leading-zero count.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_en_s) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d.sign = bus.in_sign;
        s1_d.mant = bus.in_mant;
        s1_d.exp  = bus.in_exp;
        s1_d.lz   = lz_s;
      end else begin
        s1_d = s1_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Shift select: left by lz when normal, else by the exponent (right when negative).
  always_comb begin
    exp_x_s     = $signed({s1_q.exp[XW-1], s1_q.exp});
    lz_x_s      = $signed({{(XW + 1 - LZW){1'b0}}, s1_q.lz});
    neg_exp_s   = -exp_x_s;
    exp_full_s  = exp_x_s + (XW + 1)'(1) - lz_x_s;
    lsh_s       = {LZW{1'b0}};
    rsh_s       = {LZW{1'b0}};
    use_right_s = 1'b0;
    norm_s      = '0;
    norm_s.sign = s1_q.sign;
    if (lz_x_s <= exp_x_s) begin
      lsh_s      = s1_q.lz;
      norm_s.exp = sat_exp(exp_full_s);
    end else if (!exp_x_s[XW]) begin
      lsh_s = s1_q.exp[LZW-1:0];
    end else begin
      use_right_s = 1'b1;
      if (neg_exp_s >= $signed((XW + 1)'(W))) begin
        rsh_s = LZW'(W);
      end else begin
        rsh_s = neg_exp_s[LZW-1:0];
      end
    end

    shl_s  = s1_q.mant << lsh_s;
    ext_s  = {s1_q.mant, {W{1'b0}}} >> rsh_s;
    shv_s  = use_right_s ? ext_s[2*W-1:W] : shl_s;
    lost_s = use_right_s & (|ext_s[W-1:0]);

    norm_s.mant   = shv_s[W-1:W-1-M];
    norm_s.guard  = shv_s[W-2-M];
    norm_s.round  = shv_s[W-3-M];
    norm_s.sticky = (|shv_s[W-4-M:0]) | lost_s;

    if (s1_q.mant == {W{1'b0}}) begin
      norm_s      = '0;
      norm_s.sign = s1_q.sign;
      norm_s.zero = 1'b1;
    end else begin
      norm_s.zero = 1'b0;
    end
  end

  // S2 load: advance S1 into the output register when downstream has room.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (s2_en_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = norm_s;
      end else begin
        out_d = out_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sign   = out_q.sign;
  assign bus.out_mant   = out_q.mant;
  assign bus.out_exp    = out_q.exp;
  assign bus.out_guard  = out_q.guard;
  assign bus.out_round  = out_q.round;
  assign bus.out_sticky = out_q.sticky;
  assign bus.out_zero   = out_q.zero;

endmodule

// File: tb/tb_fp_normalize.sv
// Directed bench for fp_normalize: value-level reference model, scoreboard
// with hold checking, plus literal expectations for the key vectors.
module tb_fp_normalize;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fp_normalize_if bus ();
  fp_normalize dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  fp_norm_t exp_q[$];
  fp_norm_t held;
  logic     held_v = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  // Reference: locate the leading one, pick the exponent, then align the value.
  function automatic fp_norm_t model(input logic s, input logic [W-1:0] m, input int e);
    fp_norm_t     r;
    int           top, lz, ev, sh;
    logic [127:0] v, orig;
    logic         lost;
    r = '0;
    r.sign = s;
    if (m == '0) begin
      r.zero = 1'b1;
      return r;
    end
    top = 0;
    for (int i = 0; i < W; i++) if (m[i]) top = i;
    lz = W - 1 - top;
    if (lz <= e) begin
      ev = e + 1 - lz;
      if (ev > (1 << (E + 1)) - 1) ev = (1 << (E + 1)) - 1;
      sh = lz;
    end else begin
      ev = 0;
      sh = e;
    end
    v = 128'(m);
    orig = v;
    lost = 1'b0;
    if (sh >= 0) v = v << sh;
    else begin
      v = v >> (-sh);
      lost = ((v << (-sh)) != orig);
    end
    r.exp    = ev[E:0];
    r.mant   = v[W-1 -: M+1];
    r.guard  = v[W-2-M];
    r.round  = v[W-3-M];
    r.sticky = (|v[W-4-M:0]) | lost;
    return r;
  endfunction

  function automatic fp_norm_t cur_out();
    fp_norm_t c;
    c.sign = bus.out_sign;   c.mant = bus.out_mant;     c.exp  = bus.out_exp;
    c.guard = bus.out_guard; c.round = bus.out_round;   c.sticky = bus.out_sticky;
    c.zero = bus.out_zero;
    return c;
  endfunction

  // Scoreboard and stall-hold monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    fp_norm_t c;
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      c = cur_out();
      if (held_v) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        if (bus.out_valid) check("hold_data", 64'(c), 64'(held));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'(bus.out_valid), 64'd0);
        else begin
          check("scoreboard", 64'(c), 64'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
        held_v = !bus.out_ready;
        held = c;
      end else begin
        held_v = 1'b0;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_sign, bus.in_mant, int'(bus.in_exp)));
    end
  end

  task automatic send(input logic s, input logic [W-1:0] m, input logic signed [XW-1:0] e);
    bit acc;
    int n;
    bus.in_valid = 1'b1; bus.in_sign = s; bus.in_mant = m; bus.in_exp = e;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("accept_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] m, input int e,
                          input logic [M:0] xm, input logic [E:0] xe,
                          input logic [2:0] xgrs, input logic xz);
    fp_norm_t mdl;
    mdl = model(1'b0, m, e);
    check({name, "_model"},
          64'({mdl.mant, mdl.exp, mdl.guard, mdl.round, mdl.sticky, mdl.zero}),
          64'({xm, xe, xgrs, xz}));
    send(1'b0, m, XW'(e));
    @(negedge clk);
    check({name, "_lat_early"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({name, "_lat"}, 64'(bus.out_valid), 64'd1);
    check(name, 64'({bus.out_mant, bus.out_exp, bus.out_guard, bus.out_round,
                     bus.out_sticky, bus.out_zero}),
          64'({xm, xe, xgrs, xz}));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  localparam int NV = 16;
  logic [W-1:0] vm [NV] = '{48'h4000_0000_0000, 48'h8000_0000_0001, 48'h0000_0100_0000,
                            48'h4000_0000_0000, 48'h0000_0000_0000, 48'hC000_0000_0000,
                            48'h0000_0000_0001, 48'h0000_0000_0001, 48'h4000_0000_0003,
                            48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC,
                            48'h0000_0000_0002, 48'h0123_4567_89AB, 48'h0000_00FF_FFFF,
                            48'h8000_0000_0000};
  int   ve [NV] = '{127, 127, 127, -2, 55, 511, 10, 47, -1, -47, -48, -512, 0, 3, 200, 0};
  logic vs [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] pat = 8'b1011_0110;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_mant = '0; bus.in_exp = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_data", 64'(cur_out()), 64'd0);
    @(posedge clk); #1;

    directed("r035", 48'h4000_0000_0000, 127, 24'h800000, 9'd127, 3'b000, 1'b0);
    directed("r036", 48'h8000_0000_0001, 127, 24'h800000, 9'd128, 3'b001, 1'b0);
    directed("r037", 48'h0000_0100_0000, 127, 24'h800000, 9'd105, 3'b000, 1'b0);
    directed("r038_denorm", 48'h4000_0000_0000, -2, 24'h100000, 9'd0, 3'b000, 1'b0);
    directed("r038_zero", 48'h0000_0000_0000, 99, 24'h000000, 9'd0, 3'b000, 1'b1);
    directed("exp_sat", 48'hC000_0000_0000, 511, 24'hC00000, 9'd511, 3'b000, 1'b0);
    directed("rsh_ge_w", 48'hFFFF_FFFF_FFFF, -48, 24'h000000, 9'd0, 3'b001, 1'b0);

    // Streaming with an irregular downstream ready pattern.
    fork
      begin
        for (int i = 0; i < NV; i++) send(vs[i], vm[i], XW'(ve[i]));
      end
      begin
        for (int c = 0; c < 40; c++) begin
          bus.out_ready = pat[c % 8];
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Back-pressure: two beats fill the pipe, the third must wait.
    bus.out_ready = 1'b0;
    send(1'b0, 48'h0000_0000_00F0, XW'(60));
    send(1'b1, 48'h0F00_0000_0000, XW'(-3));
    bus.in_valid = 1'b1; bus.in_sign = 1'b0;
    bus.in_mant = 48'h0000_0ABC_0000; bus.in_exp = XW'(300);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(1'b0, 48'h0000_0ABC_0000, XW'(300));
    drain();

    // Reset with both stages full discards everything in flight.
    bus.out_ready = 1'b0;
    send(1'b0, 48'h0000_1234_0000, XW'(20));
    send(1'b1, 48'h0000_0000_5555, XW'(-5));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_data", 64'(cur_out()), 64'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(bus.out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the run completed");
    $fatal(1, "watchdog");
  end

endmodule
